// File: rtl/fib_checker.sv
// fib_checker: tracks a Fibonacci stream, predicts the next term, and flags mismatches.
// Optional macro FIB_CHK_RESYNC_EN: a mismatching term reseeds the tracker.
//
// Parameters
//   WIDTH      : data width of one term (sums wrap modulo 2^WIDTH)
//   CNT_W      : width of the term, error and run counters (they saturate)
//   LOCK_TERMS : consecutive matches needed before locked is asserted
// Ports
//   clk       : clock; every state update happens on its rising edge
//   rst       : synchronous active-high reset, overrides in_valid
//   in_valid  : in_data carries a new term this cycle
//   in_data   : term from the upstream generator
//   exp_valid : exp_data holds a prediction (tracker is in TRACK)
//   exp_data  : next expected term, (a+b) mod 2^WIDTH, else 0
//   locked    : LOCK_TERMS or more consecutive matches seen
//   err       : one-cycle pulse after a mismatching term
//   term_cnt  : number of matching terms
//   err_cnt   : number of mismatching terms
module fib_checker #(
   parameter int WIDTH      = 4,
   parameter int CNT_W      = 8,
   parameter int LOCK_TERMS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             exp_valid,
   output logic [WIDTH-1:0] exp_data,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] term_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEED1 = 2'd1,
      TRACK = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_TERMS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;
   logic             lock_q, lock_d;
   logic             err_q, err_d;
   logic             expv_q, expv_d;
   logic [WIDTH-1:0] expd_q, expd_d;

   logic [WIDTH-1:0] sum;
   logic [CNT_W-1:0] run_inc;

   assign sum     = a_q + b_q;
   assign run_inc = (run_q == CNT_MAX) ? run_q : run_q + CNT_ONE;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      run_d   = run_q;
      tcnt_d  = tcnt_q;
      ecnt_d  = ecnt_q;
      lock_d  = lock_q;
      err_d   = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            IDLE: begin
               b_d     = in_data;
               state_d = SEED1;
            end
            SEED1: begin
               a_d     = b_q;
               b_d     = in_data;
               state_d = TRACK;
            end
            TRACK: begin
               if (in_data == sum) begin
                  a_d    = b_q;
                  b_d    = in_data;
                  run_d  = run_inc;
                  tcnt_d = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + CNT_ONE;
                  if (run_inc >= LOCK_CNT) begin
                     lock_d = 1'b1;
                  end
               end else begin
                  err_d  = 1'b1;
                  run_d  = '0;
                  lock_d = 1'b0;
                  ecnt_d = (ecnt_q == CNT_MAX) ? ecnt_q : ecnt_q + CNT_ONE;
`ifdef FIB_CHK_RESYNC_EN
                  // The bad term becomes the newest seed.
                  b_d     = in_data;
                  state_d = SEED1;
`else
                  state_d = IDLE;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // Prediction is registered alongside the state it belongs to.
      expv_d = (state_d == TRACK);
      expd_d = expv_d ? WIDTH'(a_d + b_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         run_q   <= '0;
         tcnt_q  <= '0;
         ecnt_q  <= '0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         expv_q  <= 1'b0;
         expd_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         run_q   <= run_d;
         tcnt_q  <= tcnt_d;
         ecnt_q  <= ecnt_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
         expv_q  <= expv_d;
         expd_q  <= expd_d;
      end
   end

   assign exp_valid = expv_q;
   assign exp_data  = expd_q;
   assign locked    = lock_q;
   assign err       = err_q;
   assign term_cnt  = tcnt_q;
   assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_fib_checker.sv
// tb_fib_checker: directed stimulus for fib_checker against a queue-based
// model of the seeds/counters, checked every cycle plus literal pins.
module tb_fib_checker;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int LT = 4;
   localparam int MOD  = 1 << W;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          exp_valid;
   logic [W-1:0]  exp_data;
   logic          locked;
   logic          err;
   logic [CW-1:0] term_cnt;
   logic [CW-1:0] err_cnt;

   fib_checker #(.WIDTH(W), .CNT_W(CW), .LOCK_TERMS(LT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .exp_valid (exp_valid),
      .exp_data  (exp_data),
      .locked    (locked),
      .err       (err),
      .term_cnt  (term_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Model: the last (up to two) accepted seeds plus plain counters.
   int sd[$];
   int m_term = 0;
   int m_errc = 0;
   int m_run = 0;
   bit m_err = 1'b0;

   function automatic int m_pred();
      return (sd[0] + sd[1]) % MOD;
   endfunction

   task automatic m_step(input bit r, input bit v, input int d);
      m_err = 1'b0;
      if (r) begin
         sd.delete();
         m_term = 0;
         m_errc = 0;
         m_run = 0;
      end else if (v) begin
         if (sd.size() < 2) begin
            sd.push_back(d);
         end else if (d == m_pred()) begin
            sd.push_back(d);
            void'(sd.pop_front());
            if (m_term < CMAX) m_term++;
            if (m_run < CMAX) m_run++;
         end else begin
            m_err = 1'b1;
            if (m_errc < CMAX) m_errc++;
            m_run = 0;
            sd.delete();
`ifdef FIB_CHK_RESYNC_EN
            sd.push_back(d);
`endif
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req,
                  $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("exp_valid", 32'(exp_valid), 32'(sd.size() == 2));
         check("exp_data", 32'(exp_data),
               (sd.size() == 2) ? 32'(m_pred()) : 32'd0);
         check("locked", 32'(locked), 32'(m_run >= LT));
         check("err", 32'(err), 32'(m_err));
         check("term_cnt", 32'(term_cnt), 32'(m_term));
         check("err_cnt", 32'(err_cnt), 32'(m_errc));
      end
   end

   task automatic step(input bit r, input bit v, input int d);
      @(negedge clk);
      rst = r;
      in_valid = v;
      in_data = W'(d);
      m_step(r, v, d);
      @(posedge clk);
      #2;
   endtask

   task automatic feed(input int d);
      step(1'b0, 1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
   endtask

   initial begin
      int bad;
      int iters;

      step(1'b1, 1'b0, 0);
      chk_en = 1'b1;
      check("rst_exp_valid", 32'(exp_valid), 32'd0);
      check("rst_term_cnt", 32'(term_cnt), 32'd0);

      // Basic tracking and lock.
      feed(0); feed(1); feed(1); feed(2); feed(3);
      check("pre_lock", 32'(locked), 32'd0);
      feed(5);
      check("lock_rise", 32'(locked), 32'd1);
      check("term4", 32'(term_cnt), 32'd4);

      // Sum wrap: 8+13 = 21 -> 5.
      feed(8); feed(13);
      check("wrap_pred", 32'(exp_data), 32'd5);
      feed(5);
      check("wrap_term7", 32'(term_cnt), 32'd7);
      check("wrap_noerr", 32'(err), 32'd0);

      // Mismatch.
      step(1'b1, 1'b0, 0);
      feed(0); feed(1); feed(1); feed(2); feed(4);
      check("mm_err", 32'(err), 32'd1);
      check("mm_errcnt", 32'(err_cnt), 32'd1);
      check("mm_locked", 32'(locked), 32'd0);
      check("mm_expv", 32'(exp_valid), 32'd0);
      idle(1);
      check("mm_pulse", 32'(err), 32'd0);
      feed(7);
`ifdef FIB_CHK_RESYNC_EN
      check("resync_pred", 32'(exp_data), 32'd11);
`else
      check("idle_seed", 32'(exp_valid), 32'd0);
`endif

      // Gaps between terms.
      step(1'b1, 1'b0, 0);
      feed(0); feed(1); idle(5); feed(1); idle(5); feed(2);
      check("gap_term", 32'(term_cnt), 32'd2);
      check("gap_pred", 32'(exp_data), 32'd3);

      // Reset beats in_valid mid-TRACK.
      feed(3);
      step(1'b1, 1'b1, 9);
      check("rv_expv", 32'(exp_valid), 32'd0);
      check("rv_term", 32'(term_cnt), 32'd0);
      feed(3); feed(5); feed(8);
      check("rv_term1", 32'(term_cnt), 32'd1);
      check("rv_noerr", 32'(err_cnt), 32'd0);

      // Error counter saturation.
      step(1'b1, 1'b0, 0);
      bad = 0;
      iters = 0;
      while (bad < 260 && iters < 1000) begin
         iters++;
         if (sd.size() == 2) begin
            feed((m_pred() + 1) % MOD);
            bad++;
         end else begin
            feed(0);
         end
      end
      check("sat_loop", 32'(bad), 32'd260);
      check("sat_errcnt", 32'(err_cnt), 32'd255);
      check("sat_errpulse", 32'(err), 32'd1);

      // Term counter saturation on an all-zero stream.
      step(1'b1, 1'b0, 0);
      feed(0); feed(0);
      for (int i = 0; i < 260; i++) feed(0);
      check("sat_termcnt", 32'(term_cnt), 32'd255);
      check("sat_locked", 32'(locked), 32'd1);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
